// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single 32-bit data-memory port between the data
// stage, the fetch stage and the debug/loader port. Data has priority,
// fetch and loader alternate round-robin, and a starved fetch overrides data.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        sysclk,
    input  logic        rstd,
    input  logic        d_req,
    input  logic        i_req,
    input  logic        x_req,
    input  logic [7:0]  d_addr,
    input  logic [7:0]  i_addr,
    input  logic [7:0]  x_addr,
    input  logic [3:0]  d_wren,
    input  logic [3:0]  x_wren,
    input  logic [31:0] d_wdata,
    input  logic [31:0] x_wdata,
    output logic        d_gnt,
    output logic        i_gnt,
    output logic        x_gnt,
    output logic        d_rvalid,
    output logic        i_rvalid,
    output logic        x_rvalid,
    output logic [31:0] rdata,
    output logic [7:0]  mem_addr,
    output logic [3:0]  mem_wren,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned CW = 4;

    localparam logic [1:0] OWN_D = 2'd0;
    localparam logic [1:0] OWN_I = 2'd1;
    localparam logic [1:0] OWN_X = 2'd2;

    logic          rr;
    logic [CW-1:0] starve_cnt;
    logic          own_vld;
    logic [1:0]    own_tag;
    logic          rd_grant;
    logic [1:0]    rd_tag;

    // Fixed-priority grant with starvation override and fetch/loader round-robin.
    // Grants are held off entirely while reset is asserted.
    always_comb begin
        d_gnt = 1'b0;
        i_gnt = 1'b0;
        x_gnt = 1'b0;
        if (rstd) begin
            if (i_req && (starve_cnt == CW'(STARVE_LIMIT))) begin
                i_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (i_req && x_req) begin
                if (rr) x_gnt = 1'b1;
                else    i_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end else if (x_req) begin
                x_gnt = 1'b1;
            end
        end
    end

    // Steer the winner onto the bank port; idle port drives zeros.
    always_comb begin
        mem_addr  = '0;
        mem_wren  = '0;
        mem_wdata = '0;
        rd_grant  = 1'b0;
        rd_tag    = OWN_D;
        if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wren  = d_wren;
            mem_wdata = d_wdata;
            rd_grant  = (d_wren == '0);
            rd_tag    = OWN_D;
        end else if (i_gnt) begin
            mem_addr  = i_addr;
            rd_grant  = 1'b1;
            rd_tag    = OWN_I;
        end else if (x_gnt) begin
            mem_addr  = x_addr;
            mem_wren  = x_wren;
            mem_wdata = x_wdata;
            rd_grant  = (x_wren == '0);
            rd_tag    = OWN_X;
        end
    end

    // Round-robin pointer flips to favour the other side after a fetch or loader grant.
    always_ff @(posedge sysclk or negedge rstd) begin
        if (!rstd) begin
            rr <= 1'b0;
        end else if (x_gnt) begin
            rr <= 1'b0;
        end else if (i_gnt) begin
            rr <= 1'b1;
        end
    end

    // Count data-caused fetch denials; loader wins leave the count untouched.
    always_ff @(posedge sysclk or negedge rstd) begin
        if (!rstd) begin
            starve_cnt <= '0;
        end else if (!i_req || i_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt && (starve_cnt < CW'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    // Remember who owns the read data returning next cycle.
    always_ff @(posedge sysclk or negedge rstd) begin
        if (!rstd) begin
            own_vld <= 1'b0;
            own_tag <= OWN_D;
        end else begin
            own_vld <= rd_grant;
            own_tag <= rd_tag;
        end
    end

    // Tagged read-data return; rdata is quiet when no read is returning.
    always_comb begin
        d_rvalid = own_vld && (own_tag == OWN_D);
        i_rvalid = own_vld && (own_tag == OWN_I);
        x_rvalid = own_vld && (own_tag == OWN_X);
        rdata    = own_vld ? mem_rdata : DW'(0);
    end

    // Unused-width guards keep the address/lane widths tied to the port declarations.
    logic unused_w;
    assign unused_w = ^{AW'(0), BW'(0)};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: bank model, cycle-level reference arbiter and a
// read-return scoreboard, followed by directed scenarios and a random run.
module tb_dmem_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        sysclk = 1'b0;
    logic        rstd   = 1'b0;
    logic        d_req, i_req, x_req;
    logic [7:0]  d_addr, i_addr, x_addr;
    logic [3:0]  d_wren, x_wren;
    logic [31:0] d_wdata, x_wdata;
    logic        d_gnt, i_gnt, x_gnt;
    logic        d_rvalid, i_rvalid, x_rvalid;
    logic [31:0] rdata;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_wren;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic [2:0]  tag;
        logic [31:0] data;
    } rd_t;

    rd_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] bank[256];
    logic [31:0] ref_mem[256];
    logic        preload = 1'b1;
    logic        m_rr;
    int          m_cnt;
    logic [2:0]  obs_gnt, obs_rv;
    logic [31:0] obs_rdata;
    int          i_cnt;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .sysclk(sysclk), .rstd(rstd),
        .d_req(d_req), .i_req(i_req), .x_req(x_req),
        .d_addr(d_addr), .i_addr(i_addr), .x_addr(x_addr),
        .d_wren(d_wren), .x_wren(x_wren),
        .d_wdata(d_wdata), .x_wdata(x_wdata),
        .d_gnt(d_gnt), .i_gnt(i_gnt), .x_gnt(x_gnt),
        .d_rvalid(d_rvalid), .i_rvalid(i_rvalid), .x_rvalid(x_rvalid),
        .rdata(rdata),
        .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 sysclk = ~sysclk;

    // Byte-lane banks with one-cycle registered read.
    always @(posedge sysclk) begin
        if (preload) begin
            for (int a = 0; a < 256; a++) bank[a] <= (a == 16) ? 32'hDEAD_BEEF : 32'h0;
            mem_rdata <= 32'h0;
        end else begin
            for (int n = 0; n < 4; n++)
                if (mem_wren[n]) bank[mem_addr][8*n +: 8] <= mem_wdata[8*n +: 8];
            mem_rdata <= bank[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: sample at negedge, compare with the reference, advance the model.
    task automatic cycle();
        logic [2:0]  eg;
        logic [7:0]  ea;
        logic [3:0]  ew;
        logic [31:0] ed;
        rd_t         item;
        @(negedge sysclk);
        obs_gnt   = {d_gnt, i_gnt, x_gnt};
        obs_rv    = {d_rvalid, i_rvalid, x_rvalid};
        obs_rdata = rdata;
        eg = 3'b000; ea = 8'h0; ew = 4'h0; ed = 32'h0;
        if (!rstd) begin
            sb.delete();
            m_rr  = 1'b0;
            m_cnt = 0;
            check("rst_rvalid", 32'(obs_rv), 32'h0);
            check("rst_rdata", obs_rdata, 32'h0);
        end else begin
            if (i_req && m_cnt == int'(LIMIT)) eg = 3'b010;
            else if (d_req)                    eg = 3'b100;
            else if (i_req && x_req)           eg = m_rr ? 3'b001 : 3'b010;
            else if (i_req)                    eg = 3'b010;
            else if (x_req)                    eg = 3'b001;
            case (eg)
                3'b100: begin ea = d_addr; ew = d_wren; ed = d_wdata; end
                3'b010: begin ea = i_addr; end
                3'b001: begin ea = x_addr; ew = x_wren; ed = x_wdata; end
                default: ;
            endcase
            if (sb.size() > 0) begin
                item = sb.pop_front();
                check("rvalid", 32'(obs_rv), 32'(item.tag));
                check("rdata", obs_rdata, item.data);
            end else begin
                check("rvalid_idle", 32'(obs_rv), 32'h0);
            end
        end
        check("gnt", 32'(obs_gnt), 32'(eg));
        check("mem_addr", 32'(mem_addr), 32'(ea));
        check("mem_wren", 32'(mem_wren), 32'(ew));
        check("mem_wdata", mem_wdata, ed);
        if (rstd) begin
            if (eg != 3'b000 && ew == 4'h0) begin
                item.tag  = eg;
                item.data = ref_mem[ea];
                sb.push_back(item);
            end
            for (int n = 0; n < 4; n++)
                if (ew[n]) ref_mem[ea][8*n +: 8] = ed[8*n +: 8];
            if (!i_req || eg[1])                      m_cnt = 0;
            else if (eg[2] && m_cnt < int'(LIMIT))    m_cnt = m_cnt + 1;
            if (eg[1])      m_rr = 1'b1;
            else if (eg[0]) m_rr = 1'b0;
        end
        @(posedge sysclk);
        #1;
    endtask

    task automatic idle_reqs();
        d_req = 1'b0; i_req = 1'b0; x_req = 1'b0;
        d_wren = 4'h0; x_wren = 4'h0;
    endtask

    task automatic reset_pulse();
        rstd = 1'b0;
        cycle();
        rstd = 1'b1;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) ref_mem[a] = (a == 16) ? 32'hDEAD_BEEF : 32'h0;
        m_rr = 1'b0; m_cnt = 0;

        // Reset with every requester asking: nothing may be granted.
        d_req = 1'b1; i_req = 1'b1; x_req = 1'b1;
        d_addr = 8'h01; i_addr = 8'h02; x_addr = 8'h03;
        d_wren = 4'h0; x_wren = 4'h0; d_wdata = 32'h0; x_wdata = 32'h0;
        cycle();
        preload = 1'b0;
        cycle();
        rstd = 1'b1;
        cycle();
        check("rel_dgnt", 32'(obs_gnt), 32'h4);
        idle_reqs();
        cycle();

        // Fetch read latency.
        i_req = 1'b1; i_addr = 8'h10;
        cycle();
        check("rd_gnt", 32'(obs_gnt), 32'h2);
        i_req = 1'b0;
        cycle();
        check("rd_rvalid", 32'(obs_rv), 32'h2);
        check("rd_data", obs_rdata, 32'hDEAD_BEEF);
        cycle();
        check("rd_once", 32'(obs_rv), 32'h0);

        // Byte-lane write then read back.
        d_req = 1'b1; d_addr = 8'h05; d_wren = 4'b0101; d_wdata = 32'h1122_3344;
        cycle();
        d_wren = 4'h0;
        cycle();
        d_req = 1'b0;
        cycle();
        check("lane_data", obs_rdata, 32'h0022_0044);

        // Round-robin between fetch and loader from reset.
        reset_pulse();
        i_req = 1'b1; i_addr = 8'h20; x_req = 1'b1; x_addr = 8'h21;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("rr_seq", 32'(obs_gnt), (k % 2 == 0) ? 32'h2 : 32'h1);
        end
        idle_reqs();
        cycle();

        // Starvation relief with data and fetch both hammering.
        reset_pulse();
        d_req = 1'b1; d_addr = 8'h07; i_req = 1'b1; i_addr = 8'h08;
        i_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            cycle();
            check("starve_i", 32'(obs_gnt[1]), (k % 5 == 4) ? 32'h1 : 32'h0);
            if (obs_gnt[1]) i_cnt++;
        end
        check("starve_cnt_i", 32'(i_cnt), 32'd3);
        idle_reqs();
        cycle();

        // Reset arriving the cycle after a loader read drops its return.
        reset_pulse();
        x_req = 1'b1; x_addr = 8'h10;
        cycle();
        check("mid_xgnt", 32'(obs_gnt), 32'h1);
        x_req = 1'b0;
        rstd = 1'b0;
        cycle();
        check("mid_drop", 32'(obs_rv), 32'h0);
        cycle();
        rstd = 1'b1;
        cycle();
        check("mid_after", 32'(obs_rv), 32'h0);
        i_req = 1'b1; i_addr = 8'h11; x_req = 1'b1; x_addr = 8'h12;
        cycle();
        check("mid_rr0", 32'(obs_gnt), 32'h2);
        idle_reqs();
        cycle();

        // Random traffic honouring the hold-until-grant rule for data and fetch.
        for (int k = 0; k < 400; k++) begin
            rstd = ($urandom_range(0, 59) != 0);
            if (!d_req || obs_gnt[2]) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_addr  = 8'($urandom_range(0, 15));
                d_wren  = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
                d_wdata = $urandom;
            end
            if (!i_req || obs_gnt[1]) begin
                i_req  = ($urandom_range(0, 1) != 0);
                i_addr = 8'($urandom_range(0, 15));
            end
            x_req   = ($urandom_range(0, 1) != 0);
            x_addr  = 8'($urandom_range(0, 15));
            x_wren  = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            x_wdata = $urandom;
            cycle();
        end
        rstd = 1'b1;
        idle_reqs();
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
